// File: rtl/rs_decode_arbiter.sv
// Round-robin scheduler sharing one RS(15,9) GF(16) decoder between NUM_REQ requesters.
// Words go in over valid/ready, the decoder is launched by toggling decStart, and results return tagged with the requester ID.
module rs_decode_arbiter #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned MIN_WAIT = 2,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    reqValid,
    input  logic [60*NUM_REQ-1:0] reqWord,
    output logic [NUM_REQ-1:0]    reqReady,
    output logic [59:0]           decWord,
    output logic                  decStart,
    input  logic                  decBusy,
    input  logic [35:0]           decMessage,
    output logic                  rspValid,
    input  logic                  rspReady,
    output logic [35:0]           rspMessage,
    output logic [ID_W-1:0]       rspId,
    output logic                  rspTimeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_WAIT - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} stateT;

    stateT             state;
    logic [ID_W-1:0]   rrPtr;
    logic [CNT_W-1:0]  waitCnt;
    logic              grantFound;
    logic [ID_W-1:0]   grantIdx;
    logic [59:0]       grantWord;
    int unsigned       idx;

    // Search upward from the last grant, wrapping, so every requester gets a turn.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        grantWord  = '0;
        idx        = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(rrPtr) + i) % NUM_REQ;
            if (!grantFound && reqValid[idx[IDX_W-1:0]]) begin
                grantFound = 1'b1;
                grantIdx   = ID_W'(idx);
                grantWord  = reqWord[60*idx +: 60];
            end
        end
    end

    always_comb begin
        reqReady = '0;
        if (state == IDLE && grantFound) begin
            reqReady = NUM_REQ'(1) << grantIdx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rrPtr      <= ID_W'(NUM_REQ - 1);
            waitCnt    <= '0;
            decWord    <= '0;
            decStart   <= 1'b0;
            rspValid   <= 1'b0;
            rspMessage <= '0;
            rspId      <= '0;
            rspTimeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantFound) begin
                        decWord <= grantWord;
                        rspId   <= grantIdx;
                        rrPtr   <= grantIdx;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    decStart <= ~decStart;
                    waitCnt  <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    waitCnt <= waitCnt + CNT_W'(1);
                    // Normal completion is checked first so it wins over a simultaneous timeout.
                    if (waitCnt >= MIN_LAST && !decBusy) begin
                        rspMessage <= decMessage;
                        rspTimeout <= 1'b0;
                        rspValid   <= 1'b1;
                        state      <= RESP;
                    end else if (waitCnt == TO_LAST) begin
                        rspMessage <= decMessage;
                        rspTimeout <= 1'b1;
                        rspValid   <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rspReady) begin
                        rspValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_decode_arbiter.sv
// Directed bench for rs_decode_arbiter with a behavioural, error-free systematic decoder model.
// Expected grants, latencies and messages are hand-computed constants.
module tb_rs_decode_arbiter;

    localparam int TIMEOUT  = 64;
    localparam int MIN_WAIT = 2;

    localparam logic [59:0] word0 = {36'h987654321, 24'h5A3C1F};
    localparam logic [59:0] word1 = {36'hFEDCBA012, 24'hC0FFEE};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   reqValid;
    logic [119:0] reqWord;
    logic [1:0]   reqReady;
    logic [59:0]  decWord;
    logic         decStart;
    logic         decBusy;
    logic [35:0]  decMessage;
    logic         rspValid;
    logic         rspReady;
    logic [35:0]  rspMessage;
    logic [1:0]   rspId;
    logic         rspTimeout;

    int checkCount = 0;
    int errorCount = 0;
    int busyLen    = 0;
    bit stuckBusy  = 1'b0;
    int busyCnt;
    int startToggles;
    logic lastStart;

    always #5 clk = ~clk;

    rs_decode_arbiter #(
        .NUM_REQ (2),
        .ID_W    (2),
        .MIN_WAIT(MIN_WAIT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reqValid  (reqValid),
        .reqWord   (reqWord),
        .reqReady  (reqReady),
        .decWord   (decWord),
        .decStart  (decStart),
        .decBusy   (decBusy),
        .decMessage(decMessage),
        .rspValid  (rspValid),
        .rspReady  (rspReady),
        .rspMessage(rspMessage),
        .rspId     (rspId),
        .rspTimeout(rspTimeout)
    );

    // Decoder notices a toggle one edge later, then stays busy for busyLen cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastStart    <= 1'b0;
            busyCnt      <= 0;
            decMessage   <= '0;
            startToggles <= 0;
        end else begin
            lastStart <= decStart;
            if (decStart != lastStart) begin
                busyCnt      <= busyLen;
                decMessage   <= decWord[59:24];
                startToggles <= startToggles + 1;
            end else if (busyCnt != 0) begin
                busyCnt <= busyCnt - 1;
            end
        end
    end

    assign decBusy = stuckBusy || (busyCnt != 0);

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic runTxn(input string tag, input logic [1:0] valid, input bit keep,
                          input int expDelay, input int expId, input int expLat,
                          input logic expTo, input int hold);
        int tries;
        int lat;
        logic [59:0] expWord;
        logic [35:0] expMsg;
        logic [1:0]  expReady;
        expWord  = (expId == 0) ? word0 : word1;
        expMsg   = expWord[59:24];
        expReady = 2'b01 << expId;
        rspReady = (hold == 0);
        reqValid = valid;
        #1;
        tries = 0;
        while (reqReady == 2'b00 && tries < 8) begin
            @(negedge clk); #1;
            tries++;
        end
        checkValue({tag, " grant"}, 64'(reqReady), 64'(expReady));
        if (expDelay >= 0) checkValue({tag, " grantDelay"}, 64'(tries), 64'(expDelay));
        lat = 0;
        do begin
            @(negedge clk); #1;
            lat++;
            if (lat == 1) begin
                if (!keep) reqValid = 2'b00;
                checkValue({tag, " readyPulse"}, 64'(reqReady), 64'd0);
                checkValue({tag, " decWord"}, 64'(decWord), 64'(expWord));
            end
        end while (!rspValid && lat < TIMEOUT + 10);
        checkValue({tag, " latency"}, 64'(lat), 64'(expLat));
        checkValue({tag, " rspMessage"}, 64'(rspMessage), 64'(expMsg));
        checkValue({tag, " rspId"}, 64'(rspId), 64'(expId));
        checkValue({tag, " rspTimeout"}, 64'(rspTimeout), 64'(expTo));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            checkValue({tag, " holdValid"}, 64'(rspValid), 64'd1);
            checkValue({tag, " holdMessage"}, 64'(rspMessage), 64'(expMsg));
            checkValue({tag, " holdReady"}, 64'(reqReady), 64'd0);
        end
        rspReady = 1'b1;
        @(negedge clk); #1;
        checkValue({tag, " rspDone"}, 64'(rspValid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int togglesBefore;
        rst_n    = 1'b0;
        reqValid = 2'b00;
        rspReady = 1'b1;
        reqWord  = {word1, word0};
        repeat (2) @(negedge clk);
        #1;
        checkValue("reset reqReady", 64'(reqReady), 64'd0);
        checkValue("reset decStart", 64'(decStart), 64'd0);
        checkValue("reset decWord", 64'(decWord), 64'd0);
        checkValue("reset rspValid", 64'(rspValid), 64'd0);
        checkValue("reset rspMessage", 64'(rspMessage), 64'd0);
        checkValue("reset rspId", 64'(rspId), 64'd0);
        checkValue("reset rspTimeout", 64'(rspTimeout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        runTxn("basic", 2'b01, 1'b0, 0, 0, 4, 1'b0, 0);
        checkValue("basic decStart", 64'(decStart), 64'd1);

        togglesBefore = startToggles;
        runTxn("rr0", 2'b11, 1'b1, 0, 1, 4, 1'b0, 0);
        runTxn("rr1", 2'b11, 1'b1, 0, 0, 4, 1'b0, 0);
        runTxn("rr2", 2'b11, 1'b1, 0, 1, 4, 1'b0, 0);
        runTxn("rr3", 2'b11, 1'b1, 0, 0, 4, 1'b0, 0);
        checkValue("rr toggles", 64'(startToggles - togglesBefore), 64'd4);

        runTxn("hold", 2'b10, 1'b1, 0, 1, 4, 1'b0, 10);
        runTxn("lone", 2'b10, 1'b0, 0, 1, 4, 1'b0, 0);

        stuckBusy = 1'b1;
        runTxn("timeout", 2'b01, 1'b0, 0, 0, TIMEOUT + 2, 1'b1, 0);
        stuckBusy = 1'b0;
        runTxn("afterTimeout", 2'b01, 1'b0, 0, 0, 4, 1'b0, 0);

        busyLen = 3;
        runTxn("busy3", 2'b10, 1'b0, 0, 1, 7, 1'b0, 0);
        busyLen = 0;

        // Interrupt a decode for requester 0 while in WAIT.
        reqValid = 2'b01;
        #1;
        checkValue("rstTest grant", 64'(reqReady), 64'd1);
        @(negedge clk); #1;
        reqValid = 2'b00;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkValue("midReset reqReady", 64'(reqReady), 64'd0);
        checkValue("midReset decStart", 64'(decStart), 64'd0);
        checkValue("midReset decWord", 64'(decWord), 64'd0);
        checkValue("midReset rspValid", 64'(rspValid), 64'd0);
        checkValue("midReset rspMessage", 64'(rspMessage), 64'd0);
        checkValue("midReset rspId", 64'(rspId), 64'd0);
        checkValue("midReset rspTimeout", 64'(rspTimeout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runTxn("postReset", 2'b11, 1'b0, 0, 0, 4, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/rs_decode_arbiter.md
Name: rs_decode_arbiter

Overview:
- Round-robin scheduler that shares one RS(15,9) GF(16) decoder instance between NUM_REQ requesters.
- Accepts a 60-bit received word from a requester over a valid/ready handshake.
- Launches the decoder using its toggle-triggered start input, then waits for the decode to finish.
- Returns the 36-bit decoded message, tagged with the requester ID, over a valid/ready response channel.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ID_W, 2, width of the requester ID; must satisfy 2^ID_W >= NUM_REQ.
- MIN_WAIT, 2, minimum cycles after launch before decBusy is sampled.
- TIMEOUT, 64, maximum cycles in WAIT before the decode is forced to complete.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- reqValid  in  NUM_REQ  per-requester word valid.
- reqWord  in  60*NUM_REQ  per-requester received word; requester r occupies bits [60*r +: 60]; symbol i in [4*i +: 4].
- reqReady  out  NUM_REQ  one-hot accept pulse.
- decWord  out  60  word presented to the decoder.
- decStart  out  1  decoder trigger; toggles once per launch.
- decBusy  in  1  decoder busy flag.
- decMessage  in  36  decoder output message.
- rspValid  out  1  response valid.
- rspReady  in  1  response accept.
- rspMessage  out  36  decoded message.
- rspId  out  ID_W  index of the requester served.
- rspTimeout  out  1  set when the response was forced by timeout.

Behaviour:
- Reset (async, rst_n=0), all registered:
  - state=IDLE; reqReady=0; decWord=0; decStart=0.
  - rspValid=0; rspMessage=0; rspId=0; rspTimeout=0.
  - rrPtr=NUM_REQ-1, so requester 0 has first priority; wait counter=0.
- Reset mid-operation:
  - Any state returns to IDLE immediately; any pending response is dropped.
  - decStart returns to 0. A toggle caused by reset is acceptable; the decoder result is ignored.
- State IDLE:
  - If any reqValid is high, grant the first asserted requester searching upward from rrPtr+1, wrapping modulo NUM_REQ.
  - In the same cycle: reqReady[g]=1 for exactly one cycle; decWord<=reqWord[g]; rspId<=g; rrPtr<=g; next state is LAUNCH.
  - reqReady is combinational from state==IDLE and the arbitration result. A requester must hold reqWord stable while reqValid is high until it sees reqReady.
- State LAUNCH (1 cycle):
  - decStart<=~decStart; counter<=0; next state is WAIT.
  - decWord is held stable until rspValid is asserted.
- State WAIT:
  - counter increments every cycle.
  - Normal exit: when counter>=MIN_WAIT-1 and decBusy==0, capture rspMessage<=decMessage and rspTimeout<=0, then go to RESP.
  - Timeout exit: if counter==TIMEOUT-1 and decBusy is still 1, capture decMessage anyway, set rspTimeout<=1, and go to RESP.
  - If both exits are true in the same cycle, the normal exit wins.
- State RESP:
  - rspValid=1. rspMessage, rspId and rspTimeout are stable while rspValid is high.
  - When rspReady=1, rspValid<=0 and the next state is IDLE.
  - New requests are not accepted in RESP. The earliest next grant is the cycle after the handshake.
- Throughput:
  - Minimum 1 + 1 + MIN_WAIT + 1 cycles per word (accept, launch, wait, respond), with rspReady held high.
  - With defaults this is 5 cycles from reqReady to the rspValid handshake.
- Fairness:
  - With all requesters valid continuously, grants rotate 0,1,..,NUM_REQ-1,0.
  - A lone valid requester is granted back-to-back.
- rspMessage holds the decoder's bits [35:0] unchanged; symbol 6 of the codeword maps to bits [3:0].

Test Plan:
- Reset, then reqValid=01 with reqWord[59:0] set to a valid codeword whose message symbols 6..14 equal 1..9 -> exactly one reqReady=01 pulse; decStart toggles 0->1; rspValid with rspMessage=36'h987654321, rspId=0, rspTimeout=0.
- reqValid=11 held for 4 transactions with rspReady=1 -> rspId sequence 0,1,0,1; each request sees one reqReady pulse per grant; decStart toggles 4 times.
- Hold rspReady=0 for 10 cycles in RESP with reqValid=10 -> rspValid and rspMessage stay constant; reqReady stays 0; the grant to requester 1 occurs the cycle after rspReady=1.
- Model decBusy stuck at 1 -> rspValid asserts TIMEOUT+2 cycles after reqReady, with rspTimeout=1. A following normal transaction returns rspTimeout=0.
- Assert rst_n=0 during WAIT -> all outputs are 0 asynchronously. After release, a new request is served normally with rspId=0 first.
- Model decBusy falling at cycle 0 of WAIT with MIN_WAIT=2 -> the message is captured no earlier than counter=1.
